uart_tx_param: RTL and testbench

Parametrised UART transmitter that generalises the existing fixed 8N1 transmitter. It adds configurable data width, parity mode, stop-bit count and baud divisor, plus a small input FIFO so the host can queue words while a frame is on the line. It sits between the host-side byte producer and the board TX pin, and replaces the fixed-format transmitter in new designs.

---
 rtl/uart_tx_param.sv | 266 ++++++++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
//
// Parametrised UART transmitter with a small input FIFO. The host pushes words
// into the FIFO while a frame is on the line. The FSM pops one word per frame
// and shifts it out LSB first, framed as:
//   start (0), DATA_BITS data bits, optional parity bit, STOP_BITS stop bits (1).
// Every bit lasts exactly BAUD_DIV clock cycles. When the FIFO still holds a
// word at the end of a frame, the next frame starts with no idle gap.
//
// Parameters
//   BAUD_DIV    clock cycles per bit (>= 2)
//   DATA_BITS   data bits per frame (5..9)
//   PARITY      0 = none, 1 = odd, 2 = even
//   STOP_BITS   stop bits per frame (1 or 2)
//   FIFO_DEPTH  input FIFO entries (power of two, >= 2)
//
// Ports
//   clk          system clock
//   rstn         asynchronous active-low reset
//   tx_data      word to transmit, captured when tx_en_sig && tx_ready
//   tx_en_sig    write strobe, one word per high cycle
//   tx_ready     FIFO not full (combinational from the fill count)
//   tx_busy      FSM not idle (registered)
//   tx_done_sig  one-cycle pulse when a frame completes (registered)
//   tx_pin_out   serial line, idle high (registered)
// -----------------------------------------------------------------------------
module uart_tx_param #(
  parameter int BAUD_DIV   = 5208,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_en_sig,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done_sig,
  output logic                 tx_pin_out
);

  // ---------------------------------------------------------------------------
  // Derived widths and terminal counts
  // ---------------------------------------------------------------------------
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  // The bit counter doubles as the stop-bit counter; DATA_BITS >= 5 guarantees
  // it is wide enough for STOP_BITS-1.
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Parity of a data word for the configured mode
  // ---------------------------------------------------------------------------
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
    logic result;
    result = 1'b0;
    if (PARITY == 1) begin
      result = ~(^word);
    end else if (PARITY == 2) begin
      result = ^word;
    end
    return result;
  endfunction

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 fifo_wr;
  logic                 fifo_pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_head;

  assign tx_ready   = (count_q != FIFO_FULL);
  assign fifo_empty = (count_q == '0);
  // A write while full is simply ignored; a pop on the same edge does not
  // rescue it because tx_ready is derived from the registered count.
  assign fifo_wr    = tx_en_sig && tx_ready;
  assign fifo_head  = fifo_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = fifo_wr  ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = fifo_pop ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    count_d  = count_q + (AW + 1)'(fifo_wr) - (AW + 1)'(fifo_pop);
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem_q[wr_ptr_q] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM and datapath
  // ---------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [BW-1:0]        baud_cnt_q, baud_cnt_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 baud_end;
  logic                 frame_end;

  assign baud_end  = (baud_cnt_q == BAUD_LAST);
  // Last cycle of the last stop bit.
  assign frame_end = (state_q == S_STOP) && baud_end && (bit_cnt_q == STOP_LAST);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, including the counters and shift register that advance
  // alongside the state.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + BW'(1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    fifo_pop   = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          par_d    = parity_bit(fifo_head);
          state_d  = S_START;
        end
      end

      S_START: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = S_DATA;
        end
      end

      S_DATA: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            shift_d   = shift_q >> 1;
          end
        end
      end

      S_PARITY: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = S_STOP;
        end
      end

      S_STOP: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (frame_end) begin
            bit_cnt_d = '0;
            // Back-to-back: reload straight into START without an idle cycle.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_head;
              par_d    = parity_bit(fifo_head);
              state_d  = S_START;
            end else begin
              state_d  = S_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end

      default: begin
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // Output logic. Outputs are computed from the next state so the registered
  // line changes on the same edge as the state it belongs to.
  logic pin_d;
  logic busy_d;
  logic done_d;

  always_comb begin
    pin_d = 1'b1;
    case (state_d)
      S_START:  pin_d = 1'b0;
      S_DATA:   pin_d = shift_d[0];
      S_PARITY: pin_d = par_d;
      default:  pin_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = frame_end;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tx_pin_out  <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done_sig <= 1'b0;
    end else begin
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tx_pin_out  <= pin_d;
      tx_busy     <= busy_d;
      tx_done_sig <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_param
//
// Three transmitter configurations run side by side on one clock and reset:
//   cfg0: BAUD_DIV=4, 8 data bits, no parity,   1 stop, FIFO 4
//   cfg1: BAUD_DIV=3, 8 data bits, even parity, 1 stop, FIFO 4
//   cfg2: BAUD_DIV=5, 7 data bits, odd parity,  2 stop, FIFO 2
// A reference model per configuration keeps a list of accepted frames with
// their acceptance and start cycles and derives the expected line level,
// busy, done and ready values each cycle from that list.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_param;

  localparam int NCFG = 3;
  localparam int BD_T [NCFG] = '{4, 3, 5};
  localparam int DB_T [NCFG] = '{8, 8, 7};
  localparam int PAR_T[NCFG] = '{0, 2, 1};
  localparam int SB_T [NCFG] = '{1, 1, 2};
  localparam int FD_T [NCFG] = '{4, 4, 2};

  typedef struct {
    int         a;   // edge on which the word was accepted
    int         s;   // edge on which its start bit begins
    logic [8:0] w;   // data word
  } frame_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   cyc  = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic go_rst  = 1'b0;
  logic fin_rst = 1'b0;

  logic [NCFG-1:0] fin_a, armed, fin_b;
  logic [NCFG-1:0] pin_v, busy_v, rdy_v, done_v;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < NCFG; gi++) begin : g_cfg
      localparam int BD  = BD_T[gi];
      localparam int DB  = DB_T[gi];
      localparam int PAR = PAR_T[gi];
      localparam int SB  = SB_T[gi];
      localparam int FD  = FD_T[gi];
      localparam int FL  = (1 + DB + ((PAR != 0) ? 1 : 0) + SB) * BD;

      logic          en   = 1'b0;
      logic [DB-1:0] data = '0;
      logic          fa   = 1'b0;
      logic          ar   = 1'b0;
      logic          fb   = 1'b0;
      frame_t        fq[$];
      int            last_end = 0;

      assign fin_a[gi] = fa;
      assign armed[gi] = ar;
      assign fin_b[gi] = fb;

      uart_tx_param #(
        .BAUD_DIV  (BD),
        .DATA_BITS (DB),
        .PARITY    (PAR),
        .STOP_BITS (SB),
        .FIFO_DEPTH(FD)
      ) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .tx_data    (data),
        .tx_en_sig  (en),
        .tx_ready   (rdy_v[gi]),
        .tx_busy    (busy_v[gi]),
        .tx_done_sig(done_v[gi]),
        .tx_pin_out (pin_v[gi])
      );

      // Line level of bit slot idx within a frame carrying word w.
      function automatic logic frame_bit(input logic [8:0] w, input int idx);
        int ones;
        ones = $countones(w);
        if (idx == 0) return 1'b0;
        if (idx <= DB) return w[idx-1];
        if (PAR != 0 && idx == DB + 1) return ((ones % 2) == 1) ^ (PAR == 1);
        return 1'b1;
      endfunction

      // Acceptance model: a word is taken when fewer than FD words are waiting
      // (accepted but not yet started); it starts one edge after acceptance or
      // on the edge the previous frame ends, whichever is later.
      always @(posedge clk or negedge rstn) begin : p_model
        int c, occ, st;
        if (!rstn) begin
          fq.delete();
          last_end = 0;
        end else begin
          c   = cyc + 1;
          occ = 0;
          while (fq.size() > 0 && fq[0].s + FL < c) void'(fq.pop_front());
          foreach (fq[i]) if (fq[i].a < c && fq[i].s >= c) occ++;
          if (en && occ < FD) begin
            st = (c + 1 > last_end) ? c + 1 : last_end;
            fq.push_back('{a: c, s: st, w: 9'(data)});
            last_end = st + FL;
          end
        end
      end

      always @(negedge clk) begin : p_check
        int   t, cnt;
        logic ep, eb, ed;
        t   = cyc;
        cnt = 0;
        ep  = 1'b1;
        eb  = 1'b0;
        ed  = 1'b0;
        foreach (fq[i]) begin
          if (fq[i].a <= t && fq[i].s > t) cnt++;
          if (t >= fq[i].s && t < fq[i].s + FL) begin
            eb = 1'b1;
            ep = frame_bit(fq[i].w, (t - fq[i].s) / BD);
          end
          if (t == fq[i].s + FL) ed = 1'b1;
        end
        check_value($sformatf("c%0d_line@%0d", gi, t),  32'(pin_v[gi]),  32'(ep));
        check_value($sformatf("c%0d_busy@%0d", gi, t),  32'(busy_v[gi]), 32'(eb));
        check_value($sformatf("c%0d_done@%0d", gi, t),  32'(done_v[gi]), 32'(ed));
        check_value($sformatf("c%0d_ready@%0d", gi, t), 32'(rdy_v[gi]),  32'(cnt < FD));
      end

      task automatic put(input logic [8:0] w);
        @(negedge clk);
        en   = 1'b1;
        data = DB'(w);
      endtask

      // Ends a write burst and scrambles tx_data so later changes are exercised.
      task automatic pause(input int n);
        @(negedge clk);
        en   = 1'b0;
        data = DB'($urandom);
        repeat (n) @(negedge clk);
      endtask

      initial begin : p_stim
        wait (cyc >= 6);
        put(9'h055); pause(FL + 4);
        put(9'h0A3); pause(FL + 4);
        put(9'h07F); pause(FL + 4);
        put(9'h001); put(9'h002); put(9'h003); pause(3 * FL + 6);
        put(9'h00F); pause(FL / 2);
        for (int i = 0; i < 5; i++) put(9'(16 + i));
        pause((FD + 2) * FL + 4);
        for (int k = 0; k < 30; k++) begin
          int n;
          repeat ($urandom_range(0, FL)) @(negedge clk);
          n = $urandom_range(1, FD + 2);
          for (int j = 0; j < n; j++) put(9'($urandom));
          pause(0);
        end
        pause((FD + 2) * FL + 4);
        fa = 1'b1;
        wait (go_rst);
        put(9'($urandom)); put(9'($urandom)); put(9'($urandom));
        pause(0);
        ar = 1'b1;
        wait (fin_rst);
        put(9'($urandom));
        pause(FL + 4);
        fb = 1'b1;
      end
    end
  endgenerate

  initial begin : p_main
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1 rstn = 1'b1;
    wait (&fin_a);
    go_rst = 1'b1;
    wait (&armed);
    repeat (12) @(negedge clk);
    // Abort frames that are mid-DATA with words still queued.
    #1 rstn = 1'b0;
    #1;
    for (int k = 0; k < NCFG; k++) begin
      check_value($sformatf("c%0d_rst_line", k),  32'(pin_v[k]),  32'd1);
      check_value($sformatf("c%0d_rst_busy", k),  32'(busy_v[k]), 32'd0);
      check_value($sformatf("c%0d_rst_ready", k), 32'(rdy_v[k]),  32'd1);
      check_value($sformatf("c%0d_rst_done", k),  32'(done_v[k]), 32'd0);
    end
    repeat (3) @(negedge clk);
    #1 rstn = 1'b1;
    repeat (20) @(negedge clk);
    fin_rst = 1'b1;
    wait (&fin_b);
    @(negedge clk);
    finish_run();
  end

  initial begin : p_watchdog
    repeat (80000) @(posedge clk);
    check_value("timeout_all_done", 32'(fin_b), 32'(3'b111));
    finish_run();
  end

endmodule
